key_input_frontend: RTL and testbench

- Producer side of the soc's pushbutton (gpi) and switch-data (din) inputs.
- Synchronizes and debounces the active-low DE-series KEYs, and emits active-high levels plus one-cycle press pulses.
- On a press of a designated capture key, latches the switch value and offers it to the soc over a valid/ready handshake.
- Instantiated between the board pins and the soc in top.

---
 rtl/key_input_frontend.sv | 184 ++++++++++++++++++
 tb/tb_key_input_frontend.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_frontend.sv
// Key/switch front end: 2-flop sync, per-key debounce, press pulses, and a valid/ready
// capture of sw into din. Define KEY_AUTOREPEAT_EN to add held-key auto-repeat pulses.
module key_input_frontend #(
  parameter int NUM_KEYS        = 4,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CAPTURE_KEY     = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [DATA_W-1:0]   sw,
  output logic [NUM_KEYS-1:0] gpi,
  output logic [NUM_KEYS-1:0] press,
  output logic [DATA_W-1:0]   din,
  output logic                din_valid,
  input  logic                din_ready,
  output logic                overrun
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        CAPTURE_KEY < 0 || CAPTURE_KEY >= NUM_KEYS) begin : g_bad_cfg
      $error("key_input_frontend: illegal parameter combination");
    end
  endgenerate

  logic [NUM_KEYS-1:0] key_meta, key_sync, key_level;
  logic [NUM_KEYS-1:0] deb_done, rise, press_next;
  logic [DATA_W-1:0]   sw_meta, sw_sync;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  state_t              state, state_next;
  logic                load_din, set_overrun, cap;

  // Synchronizers reset to "released" for keys so a key held through reset must debounce as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  assign key_level = ~key_sync;

  always_comb begin
    deb_done = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      deb_done[i] = (key_level[i] != gpi[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  assign rise = deb_done & ~gpi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpi <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      gpi <= gpi ^ deb_done;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_level[i] == gpi[i] || deb_done[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]    rep_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_first, rep_fire;

  // A repeat is suppressed in the cycle the key is debouncing back to released.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rep_fire[i] = gpi[i] && !deb_done[i] &&
                    (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : PERIOD_LAST));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_first <= '1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!gpi[i] || deb_done[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b1;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b0;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_next = rise | rep_fire;
`else
  assign press_next = rise;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press <= '0;
    end else begin
      press <= press_next;
    end
  end

  assign cap = press[CAPTURE_KEY];

  always_comb begin
    state_next  = state;
    load_din    = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          load_din   = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (din_ready) begin
          if (cap) begin
            load_din = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (cap) begin
          set_overrun = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      din     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (load_din) begin
        din <= sw_sync;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
    end
  end

  assign din_valid = (state == HOLD);

endmodule

// File: tb/tb_key_input_frontend.sv
// Testbench for key_input_frontend: directed scenarios plus randomized key/switch/ready
// traffic checked every cycle against a history-based behavioural model.
module tb_key_input_frontend;

  localparam int NK = 4;
  localparam int DW = 8;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [DW-1:0] sw = '0;
  logic          din_ready = 1'b0;
  logic [NK-1:0] gpi, press;
  logic [DW-1:0] din;
  logic          din_valid, overrun;

  key_input_frontend #(
    .NUM_KEYS(NK), .DATA_W(DW), .DEBOUNCE_CYCLES(DB), .CAPTURE_KEY(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw),
    .gpi(gpi), .press(press), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_errors = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: a key is accepted once its last DB synced samples all disagree with gpi.
  logic [NK-1:0] m_kmeta, m_ksync, m_gpi, m_press;
  logic [DB-1:0] m_hist [NK];
  int            m_age [NK];
  logic [DW-1:0] m_swmeta, m_swsync, m_din;
  logic          m_valid, m_ovr, m_prev;

  function automatic bit repeat_due(input int age);
    if (age == 0) return 1'b1;
`ifdef KEY_AUTOREPEAT_EN
    if (age == RD) return 1'b1;
    if (age > RD && ((age - RD) % RP) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_kmeta = '1; m_ksync = '1; m_gpi = '0; m_press = '0;
      m_swmeta = '0; m_swsync = '0; m_din = '0; m_valid = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < NK; i++) begin
        m_hist[i] = '0;
        m_age[i]  = 0;
      end
    end else begin
      if (m_press[0]) begin
        if (!m_valid || din_ready) begin
          m_din   = m_swsync;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && din_ready) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < NK; i++) begin
        m_prev    = m_gpi[i];
        m_hist[i] = {m_hist[i][DB-2:0], ~m_ksync[i]};
        if (m_hist[i] == {DB{~m_prev}}) m_gpi[i] = ~m_prev;
        if (m_gpi[i] && !m_prev) m_age[i] = 0;
        else if (m_gpi[i]) m_age[i]++;
        m_press[i] = m_gpi[i] && repeat_due(m_age[i]);
      end
      m_ksync  = m_kmeta;
      m_kmeta  = key_n;
      m_swsync = m_swmeta;
      m_swmeta = sw;
    end
  end

  always @(negedge clk) begin
    if (check_en && !reset) begin
      checkOutput("gpi", 32'(gpi), 32'(m_gpi));
      checkOutput("press", 32'(press), 32'(m_press));
      checkOutput("din_valid", 32'(din_valid), 32'(m_valid));
      checkOutput("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) checkOutput("din", 32'(din), 32'(m_din));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k, input logic [DW-1:0] s, input logic r, input int n);
    key_n = k;
    sw = s;
    din_ready = r;
    tick(n);
  endtask

  // Reset is raised mid-cycle so outputs must clear before any clock edge.
  task automatic asyncReset();
    #3 reset = 1'b1;
    #1;
    checkOutput("areset_gpi", 32'(gpi), 0);
    checkOutput("areset_press", 32'(press), 0);
    checkOutput("areset_din", 32'(din), 0);
    checkOutput("areset_valid", 32'(din_valid), 0);
    checkOutput("areset_overrun", 32'(overrun), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic capturePress(input int hold);
    key_n[0] = 1'b0;
    tick(hold);
    key_n[0] = 1'b1;
    tick(8);
  endtask

  int p1_count;
  int offs[$];
  int exp_offs[$];
  int post_count;
  logic [NK-1:0] rk;

  initial begin
    tick(2);
    reset = 1'b0;
    check_en = 1'b1;
    checkOutput("rst_gpi", 32'(gpi), 0);
    checkOutput("rst_press", 32'(press), 0);
    checkOutput("rst_din", 32'(din), 0);
    checkOutput("rst_valid", 32'(din_valid), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);

    $display("[TB] reset mid-debounce");
    key_n[0] = 1'b0;
    tick(3);
    asyncReset();
    tick(5);
    checkOutput("s1_gpi_e5", 32'(gpi[0]), 0);
    tick(1);
    checkOutput("s1_gpi_e6", 32'(gpi[0]), 1);
    checkOutput("s1_press_e6", 32'(press[0]), 1);
    key_n[0] = 1'b1;
    tick(1);
    checkOutput("s1_press_e7", 32'(press[0]), 0);
    tick(8);
    din_ready = 1'b1;
    tick(1);
    din_ready = 1'b0;

    $display("[TB] bounce rejection");
    p1_count = 0;
    for (int c = 0; c < 11; c++) begin
      key_n[1] = (c == 3);
      tick(1);
      if (press[1]) p1_count++;
      if (c == 5) checkOutput("s2_gpi_restart", 32'(gpi[1]), 0);
      if (c == 8) checkOutput("s2_gpi_e9", 32'(gpi[1]), 0);
      if (c == 9) checkOutput("s2_gpi_e10", 32'(gpi[1]), 1);
    end
    key_n[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (press[1]) p1_count++;
    end
    checkOutput("s2_press_count", 32'(p1_count), 1);

    $display("[TB] capture and handshake");
    sw = 8'hA5;
    tick(3);
    key_n[0] = 1'b0;
    tick(7);
    key_n[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkOutput("s3_din", 32'(din), 32'hA5);
      checkOutput("s3_valid", 32'(din_valid), 1);
      tick(1);
    end
    din_ready = 1'b1;
    tick(1);
    din_ready = 1'b0;
    checkOutput("s3_valid_drop", 32'(din_valid), 0);

    $display("[TB] overrun");
    capturePress(7);
    checkOutput("s4_pending", 32'(din_valid), 1);
    sw = 8'h3C;
    tick(3);
    capturePress(7);
    checkOutput("s4_din_kept", 32'(din), 32'hA5);
    checkOutput("s4_overrun", 32'(overrun), 1);
    din_ready = 1'b1;
    tick(1);
    din_ready = 1'b0;
    checkOutput("s4_accepted", 32'(din_valid), 0);
    checkOutput("s4_overrun_sticky", 32'(overrun), 1);

    $display("[TB] back-to-back");
    asyncReset();
    sw = 8'hA5;
    tick(3);
    capturePress(7);
    sw = 8'h3C;
    tick(3);
    key_n[0] = 1'b0;
    tick(6);
    checkOutput("s5_press", 32'(press[0]), 1);
    checkOutput("s5_old_din", 32'(din), 32'hA5);
    din_ready = 1'b1;
    tick(1);
    din_ready = 1'b0;
    key_n[0] = 1'b1;
    checkOutput("s5_new_din", 32'(din), 32'h3C);
    checkOutput("s5_valid", 32'(din_valid), 1);
    checkOutput("s5_no_overrun", 32'(overrun), 0);
    tick(8);
    checkOutput("s5_valid_hold", 32'(din_valid), 1);
    din_ready = 1'b1;
    tick(1);
    din_ready = 1'b0;

    $display("[TB] held key repeat behaviour");
    exp_offs.push_back(0);
`ifdef KEY_AUTOREPEAT_EN
    exp_offs.push_back(8);
    exp_offs.push_back(13);
    exp_offs.push_back(18);
    exp_offs.push_back(23);
    exp_offs.push_back(28);
`endif
    key_n[2] = 1'b0;
    tick(6);
    for (int k = 0; k <= 30; k++) begin
      if (press[2]) offs.push_back(k);
      tick(1);
    end
    key_n[2] = 1'b1;
    checkOutput("s6_pulse_count", 32'(offs.size()), 32'(exp_offs.size()));
    for (int j = 0; j < exp_offs.size() && j < offs.size(); j++) begin
      checkOutput("s6_pulse_offset", 32'(offs[j]), 32'(exp_offs[j]));
    end
    for (int w = 0; w < 20 && gpi[2]; w++) tick(1);
    checkOutput("s6_released", 32'(gpi[2]), 0);
    post_count = 0;
    for (int c = 0; c < 20; c++) begin
      if (press[2]) post_count++;
      tick(1);
    end
    checkOutput("s6_no_pulse_after_release", 32'(post_count), 0);

    $display("[TB] randomized traffic");
    rk = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 11) == 0) rk[i] = ~rk[i];
      end
      applyStimulus(rk, DW'($urandom), ($urandom_range(0, 3) == 0), 1);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
